fetch: RTL and testbench

//  IF stage directly upstream of decode. Owns the PC and issues one-outstanding requests to instruction memory.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_if.sv | 10 +
 rtl/fetch_pc_sel.sv | 29 ++
 rtl/fetch.sv | 151 +++++++++++++++
 tb/tb_fetch.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    typedef struct packed {
        logic        redir;
        logic [31:0] tgt;
    } redir_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bundle between fetch (master) and imem (slave).
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_pc_sel.sv
// Redirect priority mux: trap beats late branch beats early branch.
module fetch_pc_sel
    import fetch_pkg::*;
(
    input  logic        i_trap_c,
    input  logic [31:0] i_trap_pc,
    input  logic        i_late_c,
    input  logic [31:0] i_late_pc,
    input  logic        i_early_c,
    input  logic [31:0] i_early_pc,
    output redir_t      o_sel
);

    always_comb begin
        o_sel.redir = 1'b0;
        o_sel.tgt   = 32'h0;
        if (i_trap_c) begin
            o_sel.redir = 1'b1;
            o_sel.tgt   = i_trap_pc;
        end else if (i_late_c) begin
            o_sel.redir = 1'b1;
            o_sel.tgt   = i_late_pc;
        end else if (i_early_c) begin
            o_sel.redir = 1'b1;
            o_sel.tgt   = i_early_pc;
        end
    end

endmodule

// File: rtl/fetch.sv
// IF stage: owns the PC, keeps one imem request outstanding, and fills the IF/ID register.
// state  | meaning
// S_BOOT | first cycle after reset, no request yet
// S_WAIT | request outstanding at r_addr
// S_KILL | wrong-path request outstanding; redirect to r_tgt when it returns
// S_HOLD | returned word parked in r_buf while decode stalls
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INST = FETCH_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic        branch_PC_early_contral,
    input  logic [31:0] branch_PC_early,
    input  logic        branch_PC_late_contral,
    input  logic [31:0] branch_PC_late,
    input  logic        trap_contral,
    input  logic [31:0] trap_PC,
    fetch_if.master     imem,
    output logic        if_valid,
    output logic [31:0] PC_pype0,
    output logic [31:0] PCp4_pype0,
    output logic [31:0] Instraction_pype
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_tgt;
    logic [31:0] r_buf;

    state_t      w_state_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_tgt_nxt;
    logic [31:0] w_buf_nxt;
    logic        w_ld;
    logic [31:0] w_ld_instr;
    redir_t      w_sel;

    fetch_pc_sel u_pc_sel (
        .i_trap_c   (trap_contral),
        .i_trap_pc  (trap_PC),
        .i_late_c   (branch_PC_late_contral),
        .i_late_pc  (branch_PC_late),
        .i_early_c  (branch_PC_early_contral),
        .i_early_pc (branch_PC_early),
        .o_sel      (w_sel)
    );

    assign imem.imem_addr = r_addr;

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_tgt_nxt     = r_tgt;
        w_buf_nxt     = r_buf;
        w_ld          = 1'b0;
        w_ld_instr    = r_buf;
        imem.imem_req = (r_state == S_WAIT) || (r_state == S_KILL);
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_WAIT;
                w_addr_nxt  = RESET_PC;
            end
            S_WAIT: begin
                if (w_sel.redir) begin
                    if (imem.imem_valid) begin
                        w_addr_nxt = w_sel.tgt;
                    end else begin
                        w_tgt_nxt   = w_sel.tgt;
                        w_state_nxt = S_KILL;
                    end
                end else if (imem.imem_valid) begin
                    if (keep) begin
                        w_buf_nxt   = imem.imem_rdata;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_ld       = 1'b1;
                        w_ld_instr = imem.imem_rdata;
                        w_addr_nxt = r_addr + 32'd4;
                    end
                end
            end
            S_KILL: begin
                // The handshake is never aborted; a redirect arriving with the response still wins.
                if (imem.imem_valid) begin
                    w_addr_nxt  = w_sel.redir ? w_sel.tgt : r_tgt;
                    w_state_nxt = S_WAIT;
                end else if (w_sel.redir) begin
                    w_tgt_nxt = w_sel.tgt;
                end
            end
            S_HOLD: begin
                if (w_sel.redir) begin
                    w_addr_nxt  = w_sel.tgt;
                    w_state_nxt = S_WAIT;
                end else if (!keep) begin
                    w_ld        = 1'b1;
                    w_addr_nxt  = r_addr + 32'd4;
                    w_state_nxt = S_WAIT;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_addr  <= RESET_PC;
            r_tgt   <= 32'h0;
            r_buf   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_tgt   <= w_tgt_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    // Decode's view: flush beats stall, stall beats new data, otherwise a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid         <= 1'b0;
            PC_pype0         <= 32'h0;
            PCp4_pype0       <= 32'h0;
            Instraction_pype <= NOP_INST;
        end else if (nop) begin
            if_valid         <= 1'b0;
            PC_pype0         <= 32'h0;
            PCp4_pype0       <= 32'h0;
            Instraction_pype <= NOP_INST;
        end else if (keep) begin
            if_valid         <= if_valid;
        end else if (w_ld) begin
            if_valid         <= 1'b1;
            PC_pype0         <= r_addr;
            PCp4_pype0       <= r_addr + 32'd4;
            Instraction_pype <= w_ld_instr;
        end else begin
            if_valid         <= 1'b0;
            PC_pype0         <= 32'h0;
            PCp4_pype0       <= 32'h0;
            Instraction_pype <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed vector bench for the fetch stage: per-cycle stimulus table plus a reset-during-kill sequence.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    typedef struct {
        logic        k;
        logic        n;
        logic        ec;
        logic [31:0] ep;
        logic        lc;
        logic [31:0] lp;
        logic        tc;
        logic [31:0] tp;
        logic        v;
        logic [31:0] rd;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eifv;
        logic [31:0] epc;
        logic [31:0] einstr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        keep = 1'b0;
    logic        nop = 1'b0;
    logic        ec = 1'b0;
    logic [31:0] ep = 32'h0;
    logic        lc = 1'b0;
    logic [31:0] lp = 32'h0;
    logic        tc = 1'b0;
    logic [31:0] tp = 32'h0;
    logic        if_valid;
    logic [31:0] PC_pype0;
    logic [31:0] PCp4_pype0;
    logic [31:0] Instraction_pype;

    int n_vec = 0;
    int n_err = 0;
    vec_t vq[$];

    fetch_if u_if ();

    fetch u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .keep                    (keep),
        .nop                     (nop),
        .branch_PC_early_contral (ec),
        .branch_PC_early         (ep),
        .branch_PC_late_contral  (lc),
        .branch_PC_late          (lp),
        .trap_contral            (tc),
        .trap_PC                 (tp),
        .imem                    (u_if.master),
        .if_valid                (if_valid),
        .PC_pype0                (PC_pype0),
        .PCp4_pype0              (PCp4_pype0),
        .Instraction_pype        (Instraction_pype)
    );

    always #5 clk = ~clk;

    task automatic av(input logic k, input logic n, input logic vec, input logic [31:0] vep,
                      input logic vlc, input logic [31:0] vlp, input logic vtc, input logic [31:0] vtp,
                      input logic v, input logic [31:0] rd, input logic ereq, input logic [31:0] eaddr,
                      input logic eifv, input logic [31:0] epc, input logic [31:0] einstr);
        vec_t t;
        t.k = k; t.n = n; t.ec = vec; t.ep = vep; t.lc = vlc; t.lp = vlp; t.tc = vtc; t.tp = vtp;
        t.v = v; t.rd = rd; t.ereq = ereq; t.eaddr = eaddr; t.eifv = eifv; t.epc = epc; t.einstr = einstr;
        vq.push_back(t);
    endtask

    task automatic check_out(input string name, input logic ereq, input logic [31:0] eaddr,
                             input logic eifv, input logic [31:0] epc, input logic [31:0] einstr);
        logic [31:0] epcp4;
        epcp4 = eifv ? epc + 32'd4 : 32'h0;
        n_vec++;
        if (u_if.imem_req !== ereq || u_if.imem_addr !== eaddr || if_valid !== eifv ||
            PC_pype0 !== epc || PCp4_pype0 !== epcp4 || Instraction_pype !== einstr) begin
            n_err++;
            $display("FAIL %s: got req=%0b addr=%h ifv=%0b pc=%h pcp4=%h instr=%h ; want req=%0b addr=%h ifv=%0b pc=%h pcp4=%h instr=%h",
                     name, u_if.imem_req, u_if.imem_addr, if_valid, PC_pype0, PCp4_pype0, Instraction_pype,
                     ereq, eaddr, eifv, epc, epcp4, einstr);
        end
    endtask

    initial begin
        u_if.imem_valid = 1'b0;
        u_if.imem_rdata = 32'h0;

        //  k  n  ec ep          lc lp          tc tp            v  rdata           req addr          ifv pc            instr
        // boot, first response one cycle after request, then back-to-back
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hA000_0000, 1, 32'h4,        1, 32'h0,        32'hA000_0000);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hA000_0004, 1, 32'h8,        1, 32'h4,        32'hA000_0004);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hA000_0008, 1, 32'hC,        1, 32'h8,        32'hA000_0008);
        // stall for three cycles while a response arrives
        av(1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hA000_000C, 0, 32'hC,        1, 32'h8,        32'hA000_0008);
        av(1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 32'h0,         0, 32'hC,        1, 32'h8,        32'hA000_0008);
        av(1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 32'h0,         0, 32'hC,        1, 32'h8,        32'hA000_0008);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h10,       1, 32'hC,        32'hA000_000C);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hA000_0010, 1, 32'h14,       1, 32'h10,       32'hA000_0010);
        // early branch while request outstanding, response two cycles late
        av(0, 0, 1, 32'h100,   0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h14,       0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h14,       0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, BAD,           1, 32'h100,      0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hB000_0100, 1, 32'h104,      1, 32'h100,      32'hB000_0100);
        // trap + late + early together with data: trap wins, data dropped
        av(0, 0, 1, 32'h300,   1, 32'h200,   1, 32'h80,       1, BAD,           1, 32'h80,       0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hC000_0080, 1, 32'h84,       1, 32'h80,       32'hC000_0080);
        // late beats early while a request is outstanding
        av(0, 0, 1, 32'h300,   1, 32'h200,   0, 32'h0,        0, 32'h0,         1, 32'h84,       0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, BAD,           1, 32'h200,      0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hD000_0200, 1, 32'h204,      1, 32'h200,      32'hD000_0200);
        // a newer redirect during kill overwrites the latched target
        av(0, 0, 1, 32'h300,   0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h204,      0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     1, 32'h380,   0, 32'h0,        0, 32'h0,         1, 32'h204,      0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, BAD,           1, 32'h380,      0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hD000_0380, 1, 32'h384,      1, 32'h380,      32'hD000_0380);
        // flush beats stall; flush with data still advances the PC
        av(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h384,      0, 32'h0,        NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hE000_0384, 1, 32'h388,      1, 32'h384,      32'hE000_0384);
        av(0, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hE000_0388, 1, 32'h38C,      0, 32'h0,        NOP);
        // PC wrap at the top of the address space
        av(0, 0, 0, 32'h0,     0, 32'h0,     1, 32'hFFFF_FFFC, 1, BAD,          1, 32'hFFFF_FFFC, 0, 32'h0,       NOP);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hF000_FFFC, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'hF000_FFFC);
        av(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hA000_0000, 1, 32'h4,        1, 32'h0,        32'hA000_0000);
        // redirect while parked in the hold buffer
        av(1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 32'hA000_0004, 0, 32'h4,        1, 32'h0,        32'hA000_0000);
        av(1, 0, 1, 32'h500,   0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h500,      1, 32'h0,        32'hA000_0000);
        av(0, 0, 1, 32'h40,    0, 32'h0,     0, 32'h0,        0, 32'h0,         1, 32'h500,      0, 32'h0,        NOP);

        repeat (3) @(negedge clk);
        check_out("reset_values", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            keep = vq[i].k;  nop = vq[i].n;
            ec = vq[i].ec;   ep = vq[i].ep;
            lc = vq[i].lc;   lp = vq[i].lp;
            tc = vq[i].tc;   tp = vq[i].tp;
            u_if.imem_valid = vq[i].v;
            u_if.imem_rdata = vq[i].rd;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vq[i].ereq, vq[i].eaddr, vq[i].eifv, vq[i].epc, vq[i].einstr);
            @(negedge clk);
        end

        // reset pulsed while the kill response is still outstanding
        keep = 1'b0; nop = 1'b0; ec = 1'b0; lc = 1'b0; tc = 1'b0;
        u_if.imem_valid = 1'b1;
        u_if.imem_rdata = BAD;
        rst = 1'b1;
        #1;
        check_out("rst_mid_kill", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("boot_ignores_stale", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        @(negedge clk);
        u_if.imem_rdata = 32'hA000_0000;
        @(posedge clk);
        #1;
        check_out("first_fetch_after_rst", 1'b1, 32'h4, 1'b1, 32'h0, 32'hA000_0000);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
